// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, ALUOp codes,
// datapath mux selects and the FSM state encoding.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0c;
    localparam logic [5:0] OP_ORI  = 6'h0d;
    localparam logic [5:0] OP_LUI  = 6'h0f;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2b;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_OR    = 3'b001;
    localparam logic [2:0] ALU_LUI   = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_SUB   = 3'b100;
    localparam logic [2:0] ALU_LW    = 3'b101;
    localparam logic [2:0] ALU_SW    = 3'b110;
    localparam logic [2:0] ALU_FUNCT = 3'b111;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB_ALU   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    function automatic logic is_imm_alu(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ORI) || (op == OP_ANDI) || (op == OP_LUI);
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control-word decode from the registered FSM state, with op and
// mem_ready qualifying only the few outputs that need them.
module mc_output_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCondEQ,
    output logic       PCWriteCondNE,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUOp,
    output logic       illegal_op
);

    always_comb begin
        PCWrite       = 1'b0;
        PCWriteCondEQ = 1'b0;
        PCWriteCondNE = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        MemtoReg      = 1'b0;
        RegDst        = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = SRCB_B;
        PCSrc         = PCSRC_ALU;
        ALUOp         = ALU_ADD;
        illegal_op    = 1'b0;
        case (state_t'(state))
            S_FETCH: begin
                // IR and PC only commit on the cycle the fetch actually completes
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB    = SRCB_IMM_SH2;
                illegal_op = !(op == OP_R || is_imm_alu(op) || op == OP_LW || op == OP_SW
                               || op == OP_BEQ || op == OP_BNE || op == OP_J);
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_ORI:  ALUOp = ALU_OR;
                    OP_ANDI: ALUOp = ALU_AND;
                    OP_LUI:  ALUOp = ALU_LUI;
                    default: ALUOp = ALU_ADD;
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = (op == OP_LW) ? ALU_LW : ALU_SW;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_WB_ALU: begin
                RegWrite = 1'b1;
                RegDst   = (op == OP_R);
            end
            S_WB_MEM: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA       = 1'b1;
                ALUOp         = ALU_SUB;
                PCSrc         = PCSRC_ALUOUT;
                PCWriteCondEQ = (op == OP_BEQ);
                PCWriteCondNE = (op == OP_BNE);
            end
            S_JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencing FSM: state register, next-state logic and the
// retired-instruction counter; the control word comes from mc_output_decode.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic [5:0]           op,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 PCWriteCondEQ,
    output logic                 PCWriteCondNE,
    output logic                 IorD,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 MemtoReg,
    output logic                 RegDst,
    output logic                 RegWrite,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           PCSrc,
    output logic [2:0]           ALUOp,
    output logic                 illegal_op,
    output logic [CNT_WIDTH-1:0] retired
);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;
    logic                 retire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                // Unknown opcodes fall straight back to FETCH; PC has already moved on
                if (op == OP_R)                        state_d = S_EXEC_R;
                else if (is_imm_alu(op))               state_d = S_EXEC_I;
                else if (op == OP_LW || op == OP_SW)   state_d = S_MEM_ADDR;
                else if (op == OP_BEQ || op == OP_BNE) state_d = S_BRANCH;
                else if (op == OP_J)                   state_d = S_JUMP;
                else                                   state_d = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
            S_MEM_ADDR: state_d = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: if (mem_ready) state_d = S_WB_MEM;
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        retired_d = retired_q;
        if (retire) retired_d = retired_q + CNT_WIDTH'(1);
    end

    assign retired = retired_q;

    mc_output_decode u_decode (
        .state         (state_q),
        .op            (op),
        .mem_ready     (mem_ready),
        .PCWrite       (PCWrite),
        .PCWriteCondEQ (PCWriteCondEQ),
        .PCWriteCondNE (PCWriteCondNE),
        .IorD          (IorD),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .IRWrite       (IRWrite),
        .MemtoReg      (MemtoReg),
        .RegDst        (RegDst),
        .RegWrite      (RegWrite),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .PCSrc         (PCSrc),
        .ALUOp         (ALUOp),
        .illegal_op    (illegal_op)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected control words are
// queued by the stimulus and checked by an independent monitor.
module tb_multicycle_control;

    typedef struct packed {
        logic       pcw;
        logic       ceq;
        logic       cne;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       m2r;
        logic       rdst;
        logic       rwr;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        logic       ill;
    } ctrl_t;

    typedef struct {
        string      name;
        ctrl_t      ctrl;
        logic [3:0] ret;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic [5:0] op = 6'h00;
    logic       mem_ready = 1'b0;

    logic       PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite;
    logic       IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUOp;
    logic [3:0] retired;

    exp_t       q[$];
    logic [3:0] exp_ret = 4'd0;
    int         n_chk = 0;
    int         n_fail = 0;
    bit         stim_done = 1'b0;
    bit         end_checked = 1'b0;
    ctrl_t      act;

    always #5 clk = ~clk;

    multicycle_control #(.CNT_WIDTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .op            (op),
        .mem_ready     (mem_ready),
        .PCWrite       (PCWrite),
        .PCWriteCondEQ (PCWriteCondEQ),
        .PCWriteCondNE (PCWriteCondNE),
        .IorD          (IorD),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .IRWrite       (IRWrite),
        .MemtoReg      (MemtoReg),
        .RegDst        (RegDst),
        .RegWrite      (RegWrite),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .PCSrc         (PCSrc),
        .ALUOp         (ALUOp),
        .illegal_op    (illegal_op),
        .retired       (retired)
    );

    assign act = '{pcw: PCWrite, ceq: PCWriteCondEQ, cne: PCWriteCondNE, iord: IorD,
                   mrd: MemRead, mwr: MemWrite, irw: IRWrite, m2r: MemtoReg,
                   rdst: RegDst, rwr: RegWrite, srca: ALUSrcA, srcb: ALUSrcB,
                   pcsrc: PCSrc, aluop: ALUOp, ill: illegal_op};

    // Hand-written expected control words for each state
    function automatic ctrl_t c_zero();
        return '0;
    endfunction
    function automatic ctrl_t c_fetch(input logic rdy);
        ctrl_t c = '0;
        c.mrd = 1'b1; c.srcb = 2'b01; c.irw = rdy; c.pcw = rdy;
        return c;
    endfunction
    function automatic ctrl_t c_decode(input logic ill);
        ctrl_t c = '0;
        c.srcb = 2'b11; c.ill = ill;
        return c;
    endfunction
    function automatic ctrl_t c_exec(input logic [1:0] srcb, input logic [2:0] aluop);
        ctrl_t c = '0;
        c.srca = 1'b1; c.srcb = srcb; c.aluop = aluop;
        return c;
    endfunction
    function automatic ctrl_t c_wb(input logic rdst, input logic m2r);
        ctrl_t c = '0;
        c.rwr = 1'b1; c.rdst = rdst; c.m2r = m2r;
        return c;
    endfunction
    function automatic ctrl_t c_mem(input logic wr);
        ctrl_t c = '0;
        c.iord = 1'b1; c.mrd = !wr; c.mwr = wr;
        return c;
    endfunction
    function automatic ctrl_t c_branch(input logic eq);
        ctrl_t c = '0;
        c.srca = 1'b1; c.aluop = 3'b100; c.pcsrc = 2'b01; c.ceq = eq; c.cne = !eq;
        return c;
    endfunction
    function automatic ctrl_t c_jump();
        ctrl_t c = '0;
        c.pcw = 1'b1; c.pcsrc = 2'b10;
        return c;
    endfunction

    task automatic step(input logic rst_v, input logic run_v, input logic [5:0] op_v,
                        input logic mr_v, input string nm, input ctrl_t c, input bit retires);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst_v; run = run_v; op = op_v; mem_ready = mr_v;
        if (!rst_v) exp_ret = 4'd0;
        e.name = nm; e.ctrl = c; e.ret = exp_ret;
        q.push_back(e);
        if (retires) exp_ret = exp_ret + 4'd1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_chk += 2;
            if (act !== e.ctrl) begin
                n_fail++;
                $display("FAIL %s ctrl: got %b expected %b", e.name, act, e.ctrl);
            end
            if (retired !== e.ret) begin
                n_fail++;
                $display("FAIL %s retired: got %0d expected %0d", e.name, retired, e.ret);
            end
        end else if (stim_done && !end_checked) begin
            n_chk++;
            end_checked = 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        step(1'b0, 1'b0, 6'h00, 1'b0, "reset", c_zero(), 1'b0);
        step(1'b0, 1'b1, 6'h00, 1'b1, "reset_hold", c_zero(), 1'b0);
        step(1'b1, 1'b0, 6'h00, 1'b1, "idle_norun", c_zero(), 1'b0);
        step(1'b1, 1'b1, 6'h00, 1'b1, "idle_run", c_zero(), 1'b0);
        // R-type
        step(1'b1, 1'b1, 6'h00, 1'b1, "r_fetch", c_fetch(1'b1), 1'b0);
        step(1'b1, 1'b1, 6'h00, 1'b1, "r_decode", c_decode(1'b0), 1'b0);
        step(1'b1, 1'b1, 6'h00, 1'b1, "r_exec", c_exec(2'b00, 3'b111), 1'b0);
        step(1'b1, 1'b1, 6'h00, 1'b1, "r_wb", c_wb(1'b1, 1'b0), 1'b1);
        // LW with two stall cycles in MEM_RD
        step(1'b1, 1'b1, 6'h23, 1'b1, "lw_fetch", c_fetch(1'b1), 1'b0);
        step(1'b1, 1'b1, 6'h23, 1'b0, "lw_decode", c_decode(1'b0), 1'b0);
        step(1'b1, 1'b1, 6'h23, 1'b0, "lw_addr", c_exec(2'b10, 3'b101), 1'b0);
        step(1'b1, 1'b1, 6'h23, 1'b0, "lw_rd_wait1", c_mem(1'b0), 1'b0);
        step(1'b1, 1'b1, 6'h23, 1'b0, "lw_rd_wait2", c_mem(1'b0), 1'b0);
        step(1'b1, 1'b1, 6'h23, 1'b1, "lw_rd_done", c_mem(1'b0), 1'b0);
        step(1'b1, 1'b1, 6'h23, 1'b0, "lw_wb", c_wb(1'b0, 1'b1), 1'b1);
        // BNE with a fetch stall; mem_ready low outside memory states
        step(1'b1, 1'b0, 6'h05, 1'b0, "bne_fetch_wait", c_fetch(1'b0), 1'b0);
        step(1'b1, 1'b0, 6'h05, 1'b1, "bne_fetch", c_fetch(1'b1), 1'b0);
        step(1'b1, 1'b0, 6'h05, 1'b0, "bne_decode", c_decode(1'b0), 1'b0);
        step(1'b1, 1'b0, 6'h05, 1'b0, "bne_branch", c_branch(1'b0), 1'b1);
        // BEQ
        step(1'b1, 1'b0, 6'h04, 1'b1, "beq_fetch", c_fetch(1'b1), 1'b0);
        step(1'b1, 1'b0, 6'h04, 1'b1, "beq_decode", c_decode(1'b0), 1'b0);
        step(1'b1, 1'b0, 6'h04, 1'b1, "beq_branch", c_branch(1'b1), 1'b1);
        // ORI and LUI
        step(1'b1, 1'b0, 6'h0d, 1'b1, "ori_fetch", c_fetch(1'b1), 1'b0);
        step(1'b1, 1'b0, 6'h0d, 1'b1, "ori_decode", c_decode(1'b0), 1'b0);
        step(1'b1, 1'b0, 6'h0d, 1'b1, "ori_exec", c_exec(2'b10, 3'b001), 1'b0);
        step(1'b1, 1'b0, 6'h0d, 1'b1, "ori_wb", c_wb(1'b0, 1'b0), 1'b1);
        step(1'b1, 1'b0, 6'h0f, 1'b1, "lui_fetch", c_fetch(1'b1), 1'b0);
        step(1'b1, 1'b0, 6'h0f, 1'b1, "lui_decode", c_decode(1'b0), 1'b0);
        step(1'b1, 1'b0, 6'h0f, 1'b1, "lui_exec", c_exec(2'b10, 3'b010), 1'b0);
        step(1'b1, 1'b0, 6'h0f, 1'b1, "lui_wb", c_wb(1'b0, 1'b0), 1'b1);
        // SW completing immediately
        step(1'b1, 1'b0, 6'h2b, 1'b1, "sw_fetch", c_fetch(1'b1), 1'b0);
        step(1'b1, 1'b0, 6'h2b, 1'b1, "sw_decode", c_decode(1'b0), 1'b0);
        step(1'b1, 1'b0, 6'h2b, 1'b1, "sw_addr", c_exec(2'b10, 3'b110), 1'b0);
        step(1'b1, 1'b0, 6'h2b, 1'b1, "sw_wr", c_mem(1'b1), 1'b1);
        // Illegal opcode, then a jump
        step(1'b1, 1'b0, 6'h3f, 1'b1, "ill_fetch", c_fetch(1'b1), 1'b0);
        step(1'b1, 1'b0, 6'h3f, 1'b1, "ill_decode", c_decode(1'b1), 1'b0);
        step(1'b1, 1'b0, 6'h02, 1'b1, "j_fetch", c_fetch(1'b1), 1'b0);
        step(1'b1, 1'b0, 6'h02, 1'b1, "j_decode", c_decode(1'b0), 1'b0);
        step(1'b1, 1'b0, 6'h02, 1'b1, "j_jump", c_jump(), 1'b1);
        // SW stalled, then reset mid-stall (observed before the next clock edge)
        step(1'b1, 1'b0, 6'h2b, 1'b1, "sws_fetch", c_fetch(1'b1), 1'b0);
        step(1'b1, 1'b0, 6'h2b, 1'b1, "sws_decode", c_decode(1'b0), 1'b0);
        step(1'b1, 1'b0, 6'h2b, 1'b0, "sws_addr", c_exec(2'b10, 3'b110), 1'b0);
        step(1'b1, 1'b0, 6'h2b, 1'b0, "sws_wait", c_mem(1'b1), 1'b0);
        step(1'b0, 1'b0, 6'h2b, 1'b0, "sws_reset", c_zero(), 1'b0);
        step(1'b1, 1'b0, 6'h02, 1'b1, "post_reset_idle", c_zero(), 1'b0);
        step(1'b1, 1'b1, 6'h02, 1'b1, "wrap_run", c_zero(), 1'b0);
        // 16 jumps wrap the 4-bit counter back to zero
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 6'h02, 1'b1, "wrap_fetch", c_fetch(1'b1), 1'b0);
            step(1'b1, 1'b1, 6'h02, 1'b1, "wrap_decode", c_decode(1'b0), 1'b0);
            step(1'b1, 1'b1, 6'h02, 1'b1, "wrap_jump", c_jump(), 1'b1);
        end
        step(1'b1, 1'b1, 6'h02, 1'b1, "wrap_final", c_fetch(1'b1), 1'b0);
        @(posedge clk);
        stim_done = 1'b1;
        for (int i = 0; i < 20 && !end_checked; i++) @(posedge clk);
        if (!end_checked) $display("FAIL end_of_queue: monitor never drained, %0d entries left", q.size());
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + (end_checked ? 0 : 1));
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style sequencing FSM that drives the shared single-ALU, single-memory multicycle MIPS datapath.
- Steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
- Stalls on a memory ready handshake and counts retired instructions.
- Sits beside the datapath. Its ALUOp output feeds the existing ALU-control decoder.

Parameters:
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- run  input  1  allows leaving IDLE. Sampled only in IDLE.
- op  input  6  opcode from the instruction register (IR[31:26]).
- mem_ready  input  1  memory completed the current access this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCondEQ  output  1  PC load if ALU zero=1 (BEQ).
- PCWriteCondNE  output  1  PC load if ALU zero=0 (BNE).
- IorD  output  1  memory address mux: 0=PC, 1=ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  instruction register load.
- MemtoReg  output  1  writeback mux: 1=MDR.
- RegDst  output  1  destination mux: 1=rd, 0=rt.
- RegWrite  output  1  register file write.
- ALUSrcA  output  1  ALU A mux: 0=PC, 1=A.
- ALUSrcB  output  2  ALU B mux: 00=B, 01=const 4, 10=sign/zero-ext imm, 11=imm<<2.
- PCSrc  output  2  PC mux: 00=ALU result, 01=ALUOut, 10=jump target.
- ALUOp  output  3  000 add, 001 or, 010 lui, 011 and, 100 sub, 101 add(lw), 110 add(sw), 111 R-type funct.
- illegal_op  output  1  one-cycle pulse on an unsupported opcode.
- retired  output  CNT_WIDTH  completed-instruction count.

Behaviour:
- Reset (reset=0, async): state=IDLE, retired=0, illegal_op=0. All control outputs are 0 while in reset and while in IDLE.
- Opcodes handled:
  - R=6'h00, ADDI=6'h08, ORI=6'h0d, ANDI=6'h0c, LUI=6'h0f: arithmetic/logic.
  - BEQ=6'h04, BNE=6'h05: branches.
  - LW=6'h23, SW=6'h2b: memory.
  - J=6'h02: jump.
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP.
- IDLE: leave to FETCH when run=1.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSrc=00.
  - IRWrite and PCWrite are asserted only in the cycle where mem_ready=1. The FSM then moves to DECODE.
  - While mem_ready=0 the FSM holds in FETCH with MemRead held at 1.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=000 (branch target into ALUOut).
  - Next state by op: R goes to EXEC_R. ADDI/ORI/ANDI/LUI go to EXEC_I. LW/SW go to MEM_ADDR. BEQ/BNE go to BRANCH. J goes to JUMP.
  - Any other op: pulse illegal_op for this cycle and go to FETCH. Not counted as retired. PC was already advanced.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=111, then WB_ALU with RegDst=1.
- EXEC_I:
  - ALUSrcA=1, ALUSrcB=10. ALUOp is 000/001/011/010 for ADDI/ORI/ANDI/LUI.
  - Then WB_ALU with RegDst=0.
  - op is stable from IR, so WB_ALU re-decodes op for RegDst.
- WB_ALU: RegWrite=1, MemtoReg=0, then FETCH. Retires.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=101 (LW) or 110 (SW). Goes to MEM_RD for LW, MEM_WR for SW.
- MEM_RD: MemRead=1, IorD=1. Holds until mem_ready=1, then WB_MEM.
- WB_MEM: RegWrite=1, MemtoReg=1, RegDst=0, then FETCH. Retires.
- MEM_WR: MemWrite=1, IorD=1. Holds until mem_ready=1, then FETCH. Retires on the mem_ready cycle.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=100, PCSrc=01.
  - PCWriteCondEQ=1 for BEQ, PCWriteCondNE=1 for BNE.
  - Then FETCH. Retires regardless of whether the branch is taken.
- JUMP: PCWrite=1, PCSrc=10, then FETCH. Retires.
- Latency with mem_ready tied to 1:
  - R/I-type: 4 cycles. BEQ/BNE/J: 3 cycles. LW: 5 cycles. SW: 4 cycles.
  - Each wait cycle adds 1.
- Counter: retired increments by 1 on each retiring transition and wraps modulo 2^CNT_WIDTH. No saturation.
- Simultaneous events: mem_ready is ignored in every state except FETCH, MEM_RD and MEM_WR. run is ignored outside IDLE; there is no return to IDLE except by reset.
- Reset mid-instruction (including mid-stall): immediate return to IDLE with all outputs 0. No partial register write or memory write is issued after reset is asserted.
- Glitch-free outputs: all outputs are decoded from the registered state, plus op and mem_ready where noted. No combinational path exists from op to MemWrite or RegWrite outside the states listed above.

Decomposition:
- mips_ctrl_pkg holds:
  - opcode localparams;
  - ALUOp codes;
  - ALUSrcB and PCSrc encodings;
  - state encoding (4-bit binary).
- One natural sub-module, mc_output_decode: purely combinational mapping of (state, op, mem_ready) to control outputs. The top keeps the state register, next-state logic and counter.

Test Plan:
- Reset, then run=1, mem_ready=1, op=6'h00 -> states IDLE,FETCH,DECODE,EXEC_R,WB_ALU. RegWrite=1 and RegDst=1 only in cycle 4. retired=1.
- op=6'h23 with mem_ready low for 2 cycles in MEM_RD -> MemRead=1, IorD=1 held 3 cycles. WB_MEM asserts MemtoReg=1 and RegWrite=1. Total 7 cycles. retired +1.
- op=6'h05 -> BRANCH asserts PCWriteCondNE=1, PCWriteCondEQ=0, ALUOp=100, PCSrc=01. 3 cycles total.
- op=6'h3f -> illegal_op=1 for exactly the DECODE cycle, next state FETCH, retired unchanged.
- Assert reset low during MEM_WR stall with mem_ready=0 -> MemWrite drops to 0 asynchronously, retired=0, state=IDLE.
- CNT_WIDTH=4, run 16 J instructions (op=6'h02) -> retired wraps to 0. Each J is 3 cycles and asserts PCWrite=1 with PCSrc=10 in JUMP.
